// File: rtl/rx_8b10b_decoder.sv
// rx_8b10b_decoder: 8b/10b receive decoder with running-disparity
// tracking, violation flags and a saturating error counter.
module rx_8b10b_decoder #(
  parameter logic RD_INIT = 1'b0
) (
  input  logic       Bit_Rate_10,
  input  logic       Rst,
  input  logic       enable,
  input  logic [9:0] Data_10,
  output logic [7:0] Data_8,
  output logic       K_flag,
  output logic       disp_err,
  output logic       code_err,
  output logic       valid,
  output logic       rd_state,
  output logic [7:0] err_cnt
);

  typedef enum logic {RD_NEG = 1'b0, RD_POS = 1'b1} rd_t;

  rd_t        rd_q, rd6, rd4;
  logic [5:0] sb6;
  logic [3:0] sb4, sb4d;
  logic [2:0] n6, n4;
  logic [4:0] d5;
  logic [2:0] d3;
  logic       v6, v4, de6, de4;
  logic       k28, kx7, alt7, p7, bad_pair;
  logic [3:0] alt_ok, p7_bad;
  logic       cerr, derr, kflag;

  assign sb6 = Data_10[9:4];
  assign sb4 = Data_10[3:0];
  assign n6  = 3'($countones(sb6));
  assign n4  = 3'($countones(sb4));
  assign k28 = (sb6 == 6'b001111) || (sb6 == 6'b110000);
  // K28 at RD+ carries the complemented fghj
  assign sb4d = (sb6 == 6'b110000) ? ~sb4 : sb4;

  always_comb begin
    v6 = 1'b1;
    d5 = 5'd0;
    case (sb6)
      6'b100111, 6'b011000: d5 = 5'd0;
      6'b011101, 6'b100010: d5 = 5'd1;
      6'b101101, 6'b010010: d5 = 5'd2;
      6'b110001:            d5 = 5'd3;
      6'b110101, 6'b001010: d5 = 5'd4;
      6'b101001:            d5 = 5'd5;
      6'b011001:            d5 = 5'd6;
      6'b111000, 6'b000111: d5 = 5'd7;
      6'b111001, 6'b000110: d5 = 5'd8;
      6'b100101:            d5 = 5'd9;
      6'b010101:            d5 = 5'd10;
      6'b110100:            d5 = 5'd11;
      6'b001101:            d5 = 5'd12;
      6'b101100:            d5 = 5'd13;
      6'b011100:            d5 = 5'd14;
      6'b010111, 6'b101000: d5 = 5'd15;
      6'b011011, 6'b100100: d5 = 5'd16;
      6'b100011:            d5 = 5'd17;
      6'b010011:            d5 = 5'd18;
      6'b110010:            d5 = 5'd19;
      6'b001011:            d5 = 5'd20;
      6'b101010:            d5 = 5'd21;
      6'b011010:            d5 = 5'd22;
      6'b111010, 6'b000101: d5 = 5'd23;
      6'b110011, 6'b001100: d5 = 5'd24;
      6'b100110:            d5 = 5'd25;
      6'b010110:            d5 = 5'd26;
      6'b110110, 6'b001001: d5 = 5'd27;
      6'b001110, 6'b001111,
      6'b110000:            d5 = 5'd28;
      6'b101110, 6'b010001: d5 = 5'd29;
      6'b011110, 6'b100001: d5 = 5'd30;
      6'b101011, 6'b010100: d5 = 5'd31;
      default:              v6 = 1'b0;
    endcase
  end

  always_comb begin
    v4 = 1'b1;
    d3 = 3'd0;
    case (sb4d)
      4'b1011, 4'b0100: d3 = 3'd0;
      4'b1001:          d3 = 3'd1;
      4'b0101:          d3 = 3'd2;
      4'b1100, 4'b0011: d3 = 3'd3;
      4'b1101, 4'b0010: d3 = 3'd4;
      4'b1010:          d3 = 3'd5;
      4'b0110:          d3 = 3'd6;
      4'b1110, 4'b0001,
      4'b0111, 4'b1000: d3 = 3'd7;
      default:          v4 = 1'b0;
    endcase
  end

  // Which alternate-7 fghj a 6b block may take, and which primary-7 it may not
  always_comb begin
    alt_ok = 4'b0000;
    p7_bad = 4'b0000;
    kx7    = 1'b0;
    case (sb6)
      6'b100011, 6'b010011, 6'b001011: begin
        alt_ok = 4'b0111;
        p7_bad = 4'b1110;
      end
      6'b110100, 6'b101100, 6'b011100: begin
        alt_ok = 4'b1000;
        p7_bad = 4'b0001;
      end
      6'b000101, 6'b001001, 6'b010001, 6'b100001: begin
        alt_ok = 4'b0111;
        kx7    = 1'b1;
      end
      6'b111010, 6'b110110, 6'b101110, 6'b011110: begin
        alt_ok = 4'b1000;
        kx7    = 1'b1;
      end
      6'b001111: alt_ok = 4'b1000;
      6'b110000: alt_ok = 4'b0111;
      default: ;
    endcase
  end

  assign alt7 = (sb4 == 4'b0111) || (sb4 == 4'b1000);
  assign p7   = (sb4 == 4'b1110) || (sb4 == 4'b0001);
  assign bad_pair = (alt7 && (sb4 != alt_ok)) ||
                    (p7 && ((sb4 == p7_bad) || k28));

  always_comb begin
    rd6 = rd_q;
    de6 = 1'b0;
    unique case (1'b1)
      sb6 == 6'b000111: begin rd6 = RD_POS; de6 = (rd_q == RD_NEG); end
      sb6 == 6'b111000: begin rd6 = RD_NEG; de6 = (rd_q == RD_POS); end
      n6 > 3'd3:        begin rd6 = RD_POS; de6 = (rd_q == RD_POS); end
      n6 < 3'd3:        begin rd6 = RD_NEG; de6 = (rd_q == RD_NEG); end
      default: ;
    endcase
  end

  always_comb begin
    rd4 = rd6;
    de4 = 1'b0;
    unique case (1'b1)
      sb4 == 4'b0011: begin rd4 = RD_POS; de4 = (rd6 == RD_NEG); end
      sb4 == 4'b1100: begin rd4 = RD_NEG; de4 = (rd6 == RD_POS); end
      n4 > 3'd2:      begin rd4 = RD_POS; de4 = (rd6 == RD_POS); end
      n4 < 3'd2:      begin rd4 = RD_NEG; de4 = (rd6 == RD_NEG); end
      default: ;
    endcase
  end

  assign derr  = de6 | de4;
  assign cerr  = !v6 || !v4 || bad_pair;
  assign kflag = !cerr && (k28 || (kx7 && alt7));

  always_ff @(posedge Bit_Rate_10 or negedge Rst) begin
    if (!Rst) begin
      rd_q     <= rd_t'(RD_INIT);
      Data_8   <= 8'h00;
      K_flag   <= 1'b0;
      disp_err <= 1'b0;
      code_err <= 1'b0;
      valid    <= 1'b0;
      err_cnt  <= 8'h00;
    end else begin
      valid    <= enable;
      disp_err <= 1'b0;
      code_err <= 1'b0;
      if (enable) begin
        rd_q     <= rd4;
        Data_8   <= {d3, d5};
        K_flag   <= kflag;
        disp_err <= derr;
        code_err <= cerr;
        if ((derr || cerr) && (err_cnt != 8'hFF))
          err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign rd_state = rd_q;

endmodule

// File: tb/tb_rx_8b10b_decoder.sv
// tb_rx_8b10b_decoder: scoreboard bench for the 8b/10b receive decoder.
module tb_rx_8b10b_decoder;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       k;
    logic       de;
    logic       ce;
    logic       rd;
    logic [7:0] cnt;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [9:0] data_10 = '0;
  logic [7:0] data_8;
  logic       k_flag, disp_err, code_err, valid, rd_state;
  logic [7:0] err_cnt;

  int   n_run = 0;
  int   n_fail = 0;
  res_t sb[$];

  always #5 clk = ~clk;

  rx_8b10b_decoder dut (
    .Bit_Rate_10(clk),
    .Rst        (rst_n),
    .enable     (enable),
    .Data_10    (data_10),
    .Data_8     (data_8),
    .K_flag     (k_flag),
    .disp_err   (disp_err),
    .code_err   (code_err),
    .valid      (valid),
    .rd_state   (rd_state),
    .err_cnt    (err_cnt)
  );

  // flags = {k, de, ce, rd}
  function automatic res_t mk(logic v, logic [7:0] d,
                              logic [3:0] f, logic [7:0] c);
    return {v, d, f, c};
  endfunction

  function automatic res_t obs();
    return {valid, data_8, k_flag, disp_err, code_err, rd_state, err_cnt};
  endfunction

  function automatic string fmt(res_t r);
    return $sformatf("v=%b d=%h k=%b de=%b ce=%b rd=%b cnt=%0d",
                     r.v, r.d, r.k, r.de, r.ce, r.rd, r.cnt);
  endfunction

  task automatic drive(input logic [9:0] g, input res_t e);
    @(negedge clk);
    enable  = 1'b1;
    data_10 = g;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    enable  = 1'b0;
    data_10 = 10'($urandom);
  endtask

  task automatic test_reset();
    res_t e, got;
    e = mk(1'b0, 8'h00, 4'b0000, 8'd0);
    #2 rst_n = 1'b0;
    #1 got = obs();
    n_run++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reset: got %s want %s", fmt(got), fmt(e));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_k28_alt();
    logic [9:0] g [2];
    res_t x [2];
    res_t e, got;
    g = '{10'h0FA, 10'h305};
    x = '{mk(1'b1, 8'hBC, 4'b1001, 8'd0),
          mk(1'b1, 8'hBC, 4'b1000, 8'd0)};
    for (int i = 0; i <= 2; i++) begin
      if (i < 2) drive(g[i], x[i]);
      else idle();
      if (i > 0) begin
        e = sb.pop_front();
        got = obs();
        n_run++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL k28_alt[%0d]: got %s want %s", i - 1, fmt(got), fmt(e));
        end
      end
    end
    idle();
    e = mk(1'b0, 8'hBC, 4'b1000, 8'd0);
    got = obs();
    n_run++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL k28_idle: got %s want %s", fmt(got), fmt(e));
    end
  endtask

  task automatic test_neutral();
    logic [9:0] g [2];
    res_t x [2];
    res_t e, got;
    g = '{10'h2AA, 10'h274};
    x = '{mk(1'b1, 8'hB5, 4'b0000, 8'd0),
          mk(1'b1, 8'h00, 4'b0000, 8'd0)};
    for (int i = 0; i <= 2; i++) begin
      if (i < 2) drive(g[i], x[i]);
      else idle();
      if (i > 0) begin
        e = sb.pop_front();
        got = obs();
        n_run++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL neutral[%0d]: got %s want %s", i - 1, fmt(got), fmt(e));
        end
      end
    end
  endtask

  task automatic test_disp_err();
    logic [9:0] g [3];
    res_t x [3];
    res_t e, got;
    g = '{10'h0FA, 10'h0FA, 10'h305};
    x = '{mk(1'b1, 8'hBC, 4'b1001, 8'd0),
          mk(1'b1, 8'hBC, 4'b1101, 8'd1),
          mk(1'b1, 8'hBC, 4'b1000, 8'd1)};
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) drive(g[i], x[i]);
      else idle();
      if (i > 0) begin
        e = sb.pop_front();
        got = obs();
        n_run++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL disp_err[%0d]: got %s want %s", i - 1, fmt(got), fmt(e));
        end
      end
    end
  endtask

  // Invalid groups, illegal 7-pairings, K.x.7, D.x.A7 and the D7 special blocks
  task automatic test_code_err();
    logic [9:0] g [8];
    res_t x [8];
    res_t e, got;
    g = '{10'h000, 10'h23E, 10'h057, 10'h348,
          10'h0F8, 10'h389, 10'h079, 10'h305};
    x = '{mk(1'b1, 8'h00, 4'b0110, 8'd2),
          mk(1'b1, 8'hF1, 4'b0011, 8'd3),
          mk(1'b1, 8'hF7, 4'b1001, 8'd3),
          mk(1'b1, 8'hEB, 4'b0000, 8'd3),
          mk(1'b1, 8'hFC, 4'b1000, 8'd3),
          mk(1'b1, 8'h27, 4'b0000, 8'd3),
          mk(1'b1, 8'h27, 4'b0101, 8'd4),
          mk(1'b1, 8'hBC, 4'b1000, 8'd4)};
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive(g[i], x[i]);
      else idle();
      if (i > 0) begin
        e = sb.pop_front();
        got = obs();
        n_run++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL code_err[%0d]: got %s want %s", i - 1, fmt(got), fmt(e));
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic en [9];
    logic [9:0] g [9];
    res_t x [9];
    res_t e, got;
    en = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    g  = '{10'h000, 10'h0, 10'h2AA, 10'h0, 10'h0,
           10'h0FA, 10'h0, 10'h305, 10'h0};
    x  = '{mk(1'b1, 8'h00, 4'b0110, 8'd5),
           mk(1'b0, 8'h00, 4'b0000, 8'd5),
           mk(1'b1, 8'hB5, 4'b0000, 8'd5),
           mk(1'b0, 8'hB5, 4'b0000, 8'd5),
           mk(1'b0, 8'hB5, 4'b0000, 8'd5),
           mk(1'b1, 8'hBC, 4'b1001, 8'd5),
           mk(1'b0, 8'hBC, 4'b1001, 8'd5),
           mk(1'b1, 8'hBC, 4'b1000, 8'd5),
           mk(1'b0, 8'hBC, 4'b1000, 8'd5)};
    for (int i = 0; i <= 9; i++) begin
      if (i < 9 && en[i]) drive(g[i], x[i]);
      else idle();
      if (i > 0) begin
        e = en[i-1] ? sb.pop_front() : x[i-1];
        got = obs();
        n_run++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL gaps[%0d]: got %s want %s", i - 1, fmt(got), fmt(e));
        end
      end
    end
  endtask

  task automatic test_back_to_back_sat();
    res_t e, got;
    logic [7:0] c;
    c = 8'd5;
    for (int i = 0; i <= 300; i++) begin
      if (i < 300) begin
        if (c != 8'hFF) c = c + 8'd1;
        drive(10'h3FF, mk(1'b1, 8'h00, 4'b0111, c));
      end else idle();
      if (i > 0) begin
        e = sb.pop_front();
        got = obs();
        n_run++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL sat[%0d]: got %s want %s", i - 1, fmt(got), fmt(e));
        end
      end
    end
    n_run++;
    if (err_cnt !== 8'hFF) begin
      n_fail++;
      $display("FAIL sat_final: err_cnt got %0d want 255", err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    res_t e, got;
    @(negedge clk);
    enable  = 1'b1;
    data_10 = 10'h0FA;
    #2 rst_n = 1'b0;
    #1 got = obs();
    e = mk(1'b0, 8'h00, 4'b0000, 8'd0);
    n_run++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reset_async: got %s want %s", fmt(got), fmt(e));
    end
    @(posedge clk);
    #1 got = obs();
    n_run++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reset_wins: got %s want %s", fmt(got), fmt(e));
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(mk(1'b1, 8'hBC, 4'b1001, 8'd0));
    idle();
    e = sb.pop_front();
    got = obs();
    n_run++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reset_first: got %s want %s", fmt(got), fmt(e));
    end
  endtask

  initial begin
    test_reset();
    test_k28_alt();
    test_neutral();
    test_disp_err();
    test_code_err();
    test_gaps();
    test_back_to_back_sat();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
